vedic_mul_pipe: RTL

- Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier for the ALU datapath. Generalises the combinational 4-bit Vedic multiplier to any power-of-two WIDTH.
- Adds signed/unsigned mode, a valid/ready handshake with backpressure, and fixed 3-cycle latency.
- Sits between the ALU operand registers and the result mux. One product per cycle when not stalled.

---
 rtl/vedic_mul_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier with signed/unsigned mode
// and a valid/ready handshake; a stall freezes every stage including the output.

module vedic_core #(
  parameter int W = 4
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);

  generate
    if (W == 2) begin : g_leaf
      logic c;
      assign c = x[1] & y[0] & x[0] & y[1];
      assign p = {x[1] & y[1] & c, (x[1] & y[1]) ^ c,
                  (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
    end else begin : g_rec
      localparam int M = W / 2;
      logic [W-1:0]   hh, hl, lh, ll;
      logic [2*W-1:0] mid;

      vedic_core #(.W(M)) u_hh (.x(x[W-1:M]), .y(y[W-1:M]), .p(hh));
      vedic_core #(.W(M)) u_hl (.x(x[W-1:M]), .y(y[M-1:0]), .p(hl));
      vedic_core #(.W(M)) u_lh (.x(x[M-1:0]), .y(y[W-1:M]), .p(lh));
      vedic_core #(.W(M)) u_ll (.x(x[M-1:0]), .y(y[M-1:0]), .p(ll));

      // {hh, ll} is hh<<W plus ll because ll never exceeds W bits
      assign mid = ({{W{1'b0}}, hl} + {{W{1'b0}}, lh}) << M;
      assign p   = {hh, ll} + mid;
    end
  endgenerate

endmodule

module vedic_mul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] s
);

  localparam int H = WIDTH / 2;

  logic               stall;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   a1, b1;
  logic               neg1, v1;
  logic [WIDTH-1:0]   pp_hh, pp_hl, pp_lh, pp_ll;
  logic [WIDTH-1:0]   hh2, hl2, lh2, ll2;
  logic               neg2, v2;
  logic [2*WIDTH-1:0] mid3, p3, res3;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !rst && !stall;

  // magnitude of -2^(W-1) is 2^(W-1), which still fits as unsigned
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (sgn && a[WIDTH-1]) mag_a = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
    if (sgn && b[WIDTH-1]) mag_b = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1   <= '0;
      b1   <= '0;
      neg1 <= 1'b0;
      v1   <= 1'b0;
    end else if (!stall) begin
      a1   <= mag_a;
      b1   <= mag_b;
      neg1 <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      v1   <= in_valid && in_ready;
    end
  end

  vedic_core #(.W(H)) u_hh (.x(a1[WIDTH-1:H]), .y(b1[WIDTH-1:H]), .p(pp_hh));
  vedic_core #(.W(H)) u_hl (.x(a1[WIDTH-1:H]), .y(b1[H-1:0]),     .p(pp_hl));
  vedic_core #(.W(H)) u_lh (.x(a1[H-1:0]),     .y(b1[WIDTH-1:H]), .p(pp_lh));
  vedic_core #(.W(H)) u_ll (.x(a1[H-1:0]),     .y(b1[H-1:0]),     .p(pp_ll));

  always_ff @(posedge clk) begin
    if (rst) begin
      hh2  <= '0;
      hl2  <= '0;
      lh2  <= '0;
      ll2  <= '0;
      neg2 <= 1'b0;
      v2   <= 1'b0;
    end else if (!stall) begin
      hh2  <= pp_hh;
      hl2  <= pp_hl;
      lh2  <= pp_lh;
      ll2  <= pp_ll;
      neg2 <= neg1;
      v2   <= v1;
    end
  end

  assign mid3 = ({{WIDTH{1'b0}}, hl2} + {{WIDTH{1'b0}}, lh2}) << H;
  assign p3   = {hh2, ll2} + mid3;
  assign res3 = neg2 ? (~p3 + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p3;

  // s only moves when a real product arrives; bubbles leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
    end else if (!stall) begin
      out_valid <= v2;
      if (v2) s <= res3;
    end
  end

endmodule
